// File: rtl/acm_config_loader.sv
// Sweeps the ACM lookup table from ADDR_FIRST to ADDR_LAST and issues one
// handshaked write per valid entry; a write stalled for WR_TIMEOUT cycles aborts the sweep.
module acm_config_loader #(
  parameter int unsigned ADDR_FIRST = 0,
  parameter int unsigned ADDR_LAST  = 255,
  parameter int unsigned WR_TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [8:0] WRCOUNT,
  output logic [7:0] ACMADDR,
  input  logic [7:0] ACMDATA,
  input  logic       ACMDO,
  output logic       ACM_WEN,
  output logic [7:0] ACM_ADDR,
  output logic [7:0] ACM_WDATA,
  input  logic       ACM_READY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t     r_state;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       r_wen;
  logic [8:0] r_wrcount;
  logic [7:0] r_acmaddr;
  logic [7:0] r_acm_addr;
  logic [7:0] r_acm_wdata;
  logic [7:0] r_wait;
  logic       w_last;
  logic       w_timeout;

  assign w_last    = (r_acmaddr == 8'(ADDR_LAST));
  assign w_timeout = (r_wait == 8'(WR_TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_wen       <= 1'b0;
      r_wrcount   <= 9'd0;
      r_acmaddr   <= 8'd0;
      r_acm_addr  <= 8'd0;
      r_acm_wdata <= 8'd0;
      r_wait      <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_busy    <= 1'b1;
            r_acmaddr <= 8'(ADDR_FIRST);
            r_wrcount <= 9'd0;
            r_error   <= 1'b0;
            r_state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          // Data is captured only for valid entries so invalid (don't-care) data never lands in the write register
          if (ACMDO) begin
            r_acm_addr  <= r_acmaddr;
            r_acm_wdata <= ACMDATA;
            r_wen       <= 1'b1;
            r_wait      <= 8'd0;
            r_state     <= S_WRITE;
          end else if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_acmaddr <= r_acmaddr + 8'd1;
            r_state   <= S_LOOKUP;
          end
        end
        S_WRITE: begin
          if (ACM_READY) begin
            r_wen     <= 1'b0;
            r_wrcount <= r_wrcount + 9'd1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_acmaddr <= r_acmaddr + 8'd1;
              r_state   <= S_LOOKUP;
            end
          end else if (w_timeout) begin
            r_wen   <= 1'b0;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_error;
  assign WRCOUNT   = r_wrcount;
  assign ACMADDR   = r_acmaddr;
  assign ACM_WEN   = r_wen;
  assign ACM_ADDR  = r_acm_addr;
  assign ACM_WDATA = r_acm_wdata;

endmodule

// File: tb/tb_acm_config_loader.sv
// Self-checking bench for acm_config_loader: table-driven sweep scenarios,
// randomized tables/stalls against a sweep-level reference model, and corner sequences.
module tb_acm_config_loader;

  localparam int unsigned WR_TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       ready_a = 1'b1;

  logic       busy_a, done_a, error_a, acmdo_a, wen_a;
  logic [8:0] wrcount_a;
  logic [7:0] acmaddr_a, acmdata_a, acm_addr_a, acm_wdata_a;
  logic       busy_b, done_b, error_b, acmdo_b, wen_b;
  logic [8:0] wrcount_b;
  logic [7:0] acmaddr_b, acmdata_b, acm_addr_b, acm_wdata_b;

  logic [7:0] tbl_d [0:255];
  logic       tbl_v [0:255];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign acmdata_a = tbl_d[acmaddr_a];
  assign acmdo_a   = tbl_v[acmaddr_a];
  assign acmdata_b = ~acmaddr_b;
  assign acmdo_b   = (acmaddr_b != 8'd100);

  acm_config_loader #(.ADDR_FIRST(0), .ADDR_LAST(255), .WR_TIMEOUT(WR_TMO)) dut_a (
    .PCLK(clk), .PRESETN(rst_n), .START(start_a), .BUSY(busy_a), .DONE(done_a),
    .ERROR(error_a), .WRCOUNT(wrcount_a), .ACMADDR(acmaddr_a), .ACMDATA(acmdata_a),
    .ACMDO(acmdo_a), .ACM_WEN(wen_a), .ACM_ADDR(acm_addr_a), .ACM_WDATA(acm_wdata_a),
    .ACM_READY(ready_a)
  );

  acm_config_loader #(.ADDR_FIRST(254), .ADDR_LAST(255), .WR_TIMEOUT(WR_TMO)) dut_b (
    .PCLK(clk), .PRESETN(rst_n), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .ERROR(error_b), .WRCOUNT(wrcount_b), .ACMADDR(acmaddr_b), .ACMDATA(acmdata_b),
    .ACMDO(acmdo_b), .ACM_WEN(wen_b), .ACM_ADDR(acm_addr_b), .ACM_WDATA(acm_wdata_b),
    .ACM_READY(1'b1)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Write responder and monitor: per-write stall lengths, accepted writes logged
  int          stall [0:256];
  int          w_idx = 0;
  int          s_cnt = 0;
  int          wen_cnt = 0;
  bit          in_wr = 0;
  bit          prev_acc = 0;
  logic [7:0]  hold_a, hold_d;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (prev_acc) chk("wen_gap", 32'(wen_a), 32'd0);
    prev_acc = 0;
    if (wen_a) begin
      wen_cnt++;
      if (in_wr) begin
        chk("addr_hold", 32'(acm_addr_a), 32'(hold_a));
        chk("data_hold", 32'(acm_wdata_a), 32'(hold_d));
      end else begin
        hold_a = acm_addr_a;
        hold_d = acm_wdata_a;
        in_wr  = 1;
      end
      if (s_cnt >= stall[w_idx]) begin
        ready_a = 1'b1;
        obs_q.push_back({acm_addr_a, acm_wdata_a});
        w_idx++;
        s_cnt    = 0;
        prev_acc = 1;
        in_wr    = 0;
      end else begin
        ready_a = 1'b0;
        s_cnt++;
      end
    end else begin
      ready_a = 1'($urandom_range(0, 1));
      in_wr   = 0;
    end
  end

  // Sweep-level reference: cost per entry and the ordered list of expected writes
  task automatic model_sweep(input int first, input int last,
                             output int cyc, output int wr, output int err, output int wen);
    exp_q.delete();
    cyc = 0; wr = 0; err = 0; wen = 0;
    for (int a = first; a <= last; a++) begin
      if (!tbl_v[a]) begin
        cyc += 1;
      end else if (stall[wr] >= int'(WR_TMO)) begin
        cyc += 1 + int'(WR_TMO);
        wen += int'(WR_TMO);
        err = 1;
        break;
      end else begin
        cyc += 2 + stall[wr];
        wen += 1 + stall[wr];
        exp_q.push_back({8'(a), tbl_d[a]});
        wr++;
      end
    end
  endtask

  task automatic run_sweep(input int extra_at,
                           output int cyc, output int wr, output int err, output int wen);
    int m;
    bit got;
    obs_q.delete();
    w_idx = 0; s_cnt = 0; wen_cnt = 0; in_wr = 0; prev_acc = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("busy_start", 32'(busy_a), 32'd1);
    chk("addr_start", 32'(acmaddr_a), 32'd0);
    chk("err_clear", 32'(error_a), 32'd0);
    chk("cnt_clear", 32'(wrcount_a), 32'd0);
    m = 0; got = 0;
    while (!got && m < 3000) begin
      @(negedge clk);
      m++;
      start_a = (m == extra_at);
      if (done_a) begin
        got = 1;
        chk("busy_at_done", 32'(busy_a), 32'd0);
      end
    end
    start_a = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    cyc = m;
    wr  = int'(wrcount_a);
    err = int'(error_a);
    wen = wen_cnt;
    chk("write_count_list", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) chk($sformatf("write_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    chk("done_one_cycle", 32'(done_a), 32'd0);
    chk("wrcount_hold", 32'(wrcount_a), 32'(wr));
    chk("error_hold", 32'(error_a), 32'(err));
  endtask

  task automatic load_test_table();
    for (int a = 0; a < 256; a++) begin
      tbl_d[a] = ~8'(a);
      tbl_v[a] = (a != 100);
    end
  endtask

  task automatic clear_stall();
    for (int i = 0; i <= 256; i++) stall[i] = 0;
  endtask

  typedef struct {
    int stall_idx;
    int stall_len;
    int extra_at;
    int exp_cyc;
    int exp_wr;
    int exp_err;
    int exp_wen;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   cyc, wr, err, wen, mc, mw, me, mwen, dm, k, dcnt;
    logic [15:0] wb_q[$];

    vecs[0] = '{-1,    0,  0, 511, 255, 0, 255};  // baseline, addr 100 skipped
    vecs[1] = '{ 7,   15,  0,  30,   7, 1,  22};  // stall equal to timeout aborts
    vecs[2] = '{ 7,    3,  0, 514, 255, 0, 258};  // 3-cycle stall on write @7
    vecs[3] = '{ 2, 1000,  4,  20,   2, 1,  17};  // READY stuck from addr 2, stray START
    vecs[4] = '{ 7,   14,  0, 525, 255, 0, 269};  // one short of timeout succeeds
    vecs[5] = '{-1,    0, 40, 511, 255, 0, 255};  // START during BUSY ignored

    load_test_table();
    clear_stall();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_error", 32'(error_a), 32'd0);
    chk("rst_wrcount", 32'(wrcount_a), 32'd0);
    chk("rst_acmaddr", 32'(acmaddr_a), 32'd0);
    chk("rst_wen", 32'(wen_a), 32'd0);
    chk("rst_wr_addr_data", 32'({acm_addr_a, acm_wdata_a}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clear_stall();
      if (vecs[i].stall_idx >= 0) stall[vecs[i].stall_idx] = vecs[i].stall_len;
      model_sweep(0, 255, mc, mw, me, mwen);
      run_sweep(vecs[i].extra_at, cyc, wr, err, wen);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_wrcount", i), 32'(wr), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_error", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_wen_cycles", i), 32'(wen), 32'(vecs[i].exp_wen));
      repeat (3) @(negedge clk);
    end

    // Two-entry window at the top of the address space
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_busy_start", 32'(busy_b), 32'd1);
    chk("b_addr_start", 32'(acmaddr_b), 32'd254);
    dm = 0;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      if (wen_b) wb_q.push_back({acm_addr_b, acm_wdata_b});
      if (done_b && dm == 0) begin
        dm = m;
        chk("b_addr_at_done", 32'(acmaddr_b), 32'd255);
      end
    end
    chk("b_done_cycle", 32'(dm), 32'd4);
    chk("b_nwrites", 32'(wb_q.size()), 32'd2);
    if (wb_q.size() == 2) begin
      chk("b_write0", 32'(wb_q[0]), 32'h0000FE01);
      chk("b_write1", 32'(wb_q[1]), 32'h0000FF00);
    end
    chk("b_addr_idle", 32'(acmaddr_b), 32'd255);
    chk("b_wrcount", 32'(wrcount_b), 32'd2);

    // Random tables and stall patterns against the reference model
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 256; a++) begin
        tbl_v[a] = ($urandom_range(0, 3) != 0);
        tbl_d[a] = 8'($urandom);
      end
      for (int i = 0; i <= 256; i++)
        stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
      if (it == 3) stall[$urandom_range(0, 30)] = int'($urandom_range(15, 40));
      model_sweep(0, 255, mc, mw, me, mwen);
      run_sweep(0, cyc, wr, err, wen);
      chk($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'(mc));
      chk($sformatf("rnd%0d_wrcount", it), 32'(wr), 32'(mw));
      chk($sformatf("rnd%0d_error", it), 32'(err), 32'(me));
      chk($sformatf("rnd%0d_wen_cycles", it), 32'(wen), 32'(mwen));
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset while a write is pending
    load_test_table();
    clear_stall();
    stall[3] = 10;
    obs_q.delete();
    w_idx = 0; s_cnt = 0; wen_cnt = 0; in_wr = 0; prev_acc = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    k = 0;
    while (!(wen_a && w_idx == 3) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("rst_wait_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", 32'(wen_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_acmaddr", 32'(acmaddr_a), 32'd0);
    chk("arst_wr_addr_data", 32'({acm_addr_a, acm_wdata_a}), 32'd0);
    chk("arst_wrcount", 32'(wrcount_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (done_a || busy_a || wen_a) dcnt++;
    end
    chk("post_rst_idle", 32'(dcnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acm_config_loader.md
# acm_config_loader

Sequencer that walks the ACM lookup table at power-up or on command and writes each valid entry into the analog configuration port. It sits directly upstream of the ACM lookup table: it drives the table address, samples the returned data/valid pair, and issues one handshaked write per valid entry to the ACM write interface. It is controlled by a start pulse from the CoreABC-side control logic.

## Interface
- ADDR_FIRST, 0, first table address visited (0..255)
- ADDR_LAST, 255, last table address visited (ADDR_FIRST..255)
- WR_TIMEOUT, 15, max cycles ACM_WEN may be held without ACM_READY before abort (1..255)
- PCLK  in  1  clock, all state on rising edge
- PRESETN  in  1  asynchronous active-low reset
- START  in  1  one-cycle request to run a full table sweep
- BUSY  out  1  high while a sweep is in progress
- DONE  out  1  one-cycle pulse when a sweep ends (normal or aborted)
- ERROR  out  1  sticky: last sweep aborted on write timeout
- WRCOUNT  out  9  number of completed writes in current/last sweep
- ACMADDR  out  8  table address to lookup table
- ACMDATA  in  8  table data, combinational from ACMADDR
- ACMDO  in  1  table entry valid, combinational from ACMADDR
- ACM_WEN  out  1  write request to ACM port
- ACM_ADDR  out  8  write address (equals table address)
- ACM_WDATA  out  8  write data
- ACM_READY  in  1  ACM port accepts write when sampled high with ACM_WEN

## Operation
- States: IDLE, LOOKUP, WRITE, FINISH.
- IDLE: BUSY=0. START=1 → ACMADDR←ADDR_FIRST, WRCOUNT←0, ERROR←0, go LOOKUP. START while not IDLE is ignored.
- LOOKUP (exactly 1 cycle): ACMADDR stable; at edge, ACMDATA latched into ACM_WDATA, ACMADDR into ACM_ADDR. ACMDO=1 → WRITE; ACMDO=0 → advance (skip, no write).
- WRITE: ACM_WEN=1, ACM_ADDR/ACM_WDATA held constant. Edge with ACM_READY=1 → write complete, WRCOUNT+1, advance. Wait counter increments each cycle ACM_READY=0; reaching WR_TIMEOUT → ACM_WEN drops, ERROR←1, go FINISH (no further entries).
- Advance: ACMADDR==ADDR_LAST → FINISH; else ACMADDR+1 → LOOKUP. Address never wraps past 255.
- FINISH (1 cycle): DONE=1, BUSY=0, then IDLE. ERROR and WRCOUNT hold until next accepted START.
- ACMDATA value is don't-care (may be X) when ACMDO=0; it must not reach ACM_WDATA in a way that is written.

## Timing
- Reset values: BUSY=0, DONE=0, ERROR=0, WRCOUNT=0, ACMADDR=0, ACM_WEN=0, ACM_ADDR=0, ACM_WDATA=0; state IDLE. PRESETN low mid-sweep aborts immediately, ACM_WEN low asynchronously; no DONE issued.
- START sampled at edge E0: BUSY=1 and ACMADDR=ADDR_FIRST from E0.
- Per entry: skipped = 1 cycle; written = 1 + 1 + (cycles ACM_READY low).
- ACM_WEN is registered; asserted from the edge ending LOOKUP, deasserted at the edge where ACM_READY=1 is sampled. No back-to-back writes: at least one LOOKUP cycle with ACM_WEN=0 between writes.
- Timeout: ACM_WEN high for exactly WR_TIMEOUT cycles with READY low → ACM_WEN low at the following edge, FINISH next cycle.
- DONE is one cycle wide, coincident with BUSY=0.
- WRCOUNT max 256 (9 bits), no overflow.

## Test plan
- Table in test mode (ACMDO=1 except addr 100), ACM_READY tied 1, START at E0 → 255 writes, addr 100 skipped, write @5 data 0xFA, @255 data 0x00; DONE high at E0+511; WRCOUNT=255, ERROR=0.
- ACM_READY low 3 cycles on write @7 → ACM_WEN high 4 cycles, ACM_ADDR=0x07/ACM_WDATA=0xF8 stable throughout; sweep finishes 3 cycles later than baseline.
- ACM_READY stuck 0 from addr 2, WR_TIMEOUT=15 → ACM_WEN high 15 cycles, ERROR=1, DONE pulse, WRCOUNT=2, no write to addr 3.
- ADDR_FIRST=254, ADDR_LAST=255, READY=1 → writes @254 (0x01) and @255 (0x00) only, DONE at E0+4, ACMADDR stays 255.
- START pulses during BUSY → ignored, single sweep; new START after DONE clears ERROR and WRCOUNT.
- PRESETN asserted while ACM_WEN=1 → all outputs return to reset values without clock; after release, IDLE until START.
